// File: rtl/mux_rr_arbiter4.sv
// rtl/mux_rr_arbiter4.sv - round-robin arbiter driving a shared 4:1 mux into a registered valid/ready output
// Optional build macro ARB_FIXED_PRIO0_EN: requester 0 always wins when eligible; 1-3 rotate.
module mux_rr_arbiter4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [3:0]       req_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [3:0]       ack_out,
  output logic [1:0]       sel_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       ack_q, ack_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [3:0]       elig;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic             cap;
  logic [WIDTH-1:0] mux_data;

  // A requester seeing its own ack still presents stale req/data, so mask it.
  always_comb begin
    elig  = req_in & ~ack_q;
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
`ifdef ARB_FIXED_PRIO0_EN
    if (elig[0]) begin
      win   = 2'd0;
      found = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && idx != 2'd0 && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    mux_data = a_in;
    case (win)
      2'd0:    mux_data = a_in;
      2'd1:    mux_data = b_in;
      2'd2:    mux_data = c_in;
      default: mux_data = d_in;
    endcase
  end

  assign cap = found && (state_q == IDLE || ready_in);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ack_d   = 4'b0000;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (cap) begin
      data_d  = mux_data;
      sel_d   = win;
      ack_d   = 4'b0001 << win;
      valid_d = 1'b1;
      state_d = FULL;
`ifdef ARB_FIXED_PRIO0_EN
      // Pointer only walks 1..3; a win by requester 0 leaves it alone.
      if (win == 2'd0)
        ptr_d = ptr_q;
      else if (win == 2'd3)
        ptr_d = 2'd1;
      else
        ptr_d = win + 2'd1;
`else
      ptr_d = win + 2'd1;
`endif
    end else if (state_q == FULL && ready_in) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      ack_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ack_out   = ack_q;
  assign sel_out   = sel_q;
  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule
